// File: rtl/clk_reset_manager_pkg.sv
// Shared types and sizing helpers for the PLL-side clock/reset manager.
package clk_reset_manager_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_FILTER = 1024;
  localparam int DEF_RST_STAGGER = 16;
  localparam int DEF_LOSS_W      = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_ce_divider.sv
// Per-channel clock-enable divider with programmable start phase.
module clk_ce_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rst_ch,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             ce
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  assign last = div - 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      ce    <= 1'b0;
    end else if (rst_ch) begin
      count <= (phase >= div) ? '0 : phase;
      ce    <= 1'b0;
    end else if (!en) begin
      ce <= 1'b0;
    end else if (div <= DIV_W'(1)) begin
      count <= '0;
      ce    <= 1'b1;
    end else if (count == last) begin
      count <= '0;
      ce    <= 1'b1;
    end else if (count > last) begin
      // Ratio shrank below the running count: realign silently.
      count <= '0;
      ce    <= 1'b0;
    end else begin
      count <= count + 1'b1;
      ce    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_reset_manager.sv
// PLL lock qualification, staggered per-channel reset release,
// clock-enable generation and lock-loss counting on a single fast clock.
module clk_reset_manager
  import clk_reset_manager_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int RST_STAGGER = DEF_RST_STAGGER,
  parameter int LOSS_W      = DEF_LOSS_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic [NUM_CH*DIV_W-1:0] phase,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       rst_out,
  output logic                    ready,
  output logic [LOSS_W-1:0]       lock_loss_cnt
);

  localparam int FILTER_W = cnt_w(LOCK_FILTER);
  localparam int STAG_W   = cnt_w(RST_STAGGER);
  localparam int IDX_W    = cnt_w(NUM_CH);

  localparam logic [FILTER_W-1:0] FILTER_LAST = FILTER_W'(LOCK_FILTER - 1);
  localparam logic [STAG_W-1:0]   STAG_LAST   = STAG_W'(RST_STAGGER - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_CH - 1);

  logic                lock_meta;
  logic                lock_s;
  state_t              state;
  state_t              state_next;
  logic [FILTER_W-1:0] filter_cnt;
  logic [FILTER_W-1:0] filter_next;
  logic [STAG_W-1:0]   stag_cnt;
  logic [STAG_W-1:0]   stag_next;
  logic [IDX_W-1:0]    ch_idx;
  logic [IDX_W-1:0]    idx_next;
  logic [NUM_CH-1:0]   rst_next;
  logic                ready_next;
  logic                loss_inc;
  logic [NUM_CH-1:0]   ce_raw;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      filter_cnt <= '0;
      stag_cnt   <= '0;
      ch_idx     <= '0;
      rst_out    <= '1;
      ready      <= 1'b0;
    end else begin
      state      <= state_next;
      filter_cnt <= filter_next;
      stag_cnt   <= stag_next;
      ch_idx     <= idx_next;
      rst_out    <= rst_next;
      ready      <= ready_next;
    end
  end

  always_comb begin
    state_next  = state;
    filter_next = filter_cnt;
    stag_next   = stag_cnt;
    idx_next    = ch_idx;
    rst_next    = rst_out;
    loss_inc    = 1'b0;
    case (state)
      WAIT_LOCK: begin
        rst_next    = '1;
        filter_next = '0;
        if (lock_s) state_next = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          rst_next   = '1;
        end else if (filter_cnt == FILTER_LAST) begin
          state_next  = RELEASE;
          idx_next    = '0;
          stag_next   = '0;
          rst_next[0] = 1'b0;
        end else begin
          filter_next = filter_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          rst_next   = '1;
          loss_inc   = 1'b1;
        end else if (ch_idx == IDX_LAST) begin
          state_next = RUN;
        end else if (stag_cnt == STAG_LAST) begin
          stag_next = '0;
          idx_next  = ch_idx + 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(ch_idx) + 1) rst_next[i] = 1'b0;
          end
        end else begin
          stag_next = stag_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          rst_next   = '1;
          loss_inc   = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        rst_next   = '1;
      end
    endcase
    ready_next = (state_next == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_loss_cnt <= '0;
    end else if (loss_inc && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_ce_divider #(
      .DIV_W(DIV_W)
    ) u_div (
      .clock (clock),
      .reset (reset),
      .rst_ch(rst_out[g]),
      .en    (ch_en[g]),
      .div   (div[g*DIV_W +: DIV_W]),
      .phase (phase[g*DIV_W +: DIV_W]),
      .ce    (ce_raw[g])
    );
  end

  // Masking with rst_out kills a pulse already in flight on the lock-loss edge.
  assign ce_out = ce_raw & ~rst_out;

endmodule

// File: tb/tb_clk_reset_manager.sv
// Directed bench for clk_reset_manager: release timing, dividers, lock loss, async reset.
module tb_clk_reset_manager;

  logic        clock = 1'b0;
  logic        reset;
  logic        pll_locked;
  logic [15:0] div;
  logic [15:0] phase;
  logic [1:0]  ch_en;
  logic [1:0]  ce_out;
  logic [1:0]  rst_out;
  logic        ready;
  logic [7:0]  lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] rst;
    logic       rdy;
    logic [1:0] ce;
  } vec_t;

  vec_t vecs[31];

  clk_reset_manager #(
    .NUM_CH     (2),
    .DIV_W      (8),
    .LOCK_FILTER(8),
    .RST_STAGGER(4),
    .LOSS_W     (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .div          (div),
    .phase        (phase),
    .ch_en        (ch_en),
    .ce_out       (ce_out),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit got;

    reset      = 1'b1;
    pll_locked = 1'b0;
    div        = {8'd4, 8'd5};
    phase      = {8'd2, 8'd0};
    ch_en      = 2'b11;
    step();
    step();
    check("reset_rst", rst_out, 2'b11);
    check("reset_ready", ready, 1'b0);
    check("reset_ce", ce_out, 2'b00);
    check("reset_cnt", lock_loss_cnt, 8'd0);
    reset = 1'b0;
    step();

    // Release sequence and first divider pulses, cycle by cycle from lock rising.
    for (int s = 1; s <= 31; s++) begin
      vecs[s-1].cyc = s;
      vecs[s-1].rst = (s < 11) ? 2'b11 : (s < 15) ? 2'b10 : 2'b00;
      vecs[s-1].rdy = (s >= 16);
      vecs[s-1].ce  = 2'b00;
    end
    vecs[15].ce = 2'b01;
    vecs[16].ce = 2'b10;
    vecs[20].ce = 2'b11;
    vecs[24].ce = 2'b10;
    vecs[25].ce = 2'b01;
    vecs[28].ce = 2'b10;
    vecs[30].ce = 2'b01;

    pll_locked = 1'b1;
    cyc        = 0;
    for (int i = 0; i < 31; i++) begin
      step_to(vecs[i].cyc);
      check($sformatf("seq_rst_c%0d", vecs[i].cyc), rst_out, vecs[i].rst);
      check($sformatf("seq_ready_c%0d", vecs[i].cyc), ready, vecs[i].rdy);
      check($sformatf("seq_ce_c%0d", vecs[i].cyc), ce_out, vecs[i].ce);
    end

    // Enable hold, then ratio shrink below the running count.
    for (int s = 32; s <= 64; s++) begin
      step_to(s);
      check($sformatf("ce0_c%0d", s), ce_out[0], (s == 46 || s == 51 || s == 61 || s == 64));
      if (s == 33) ch_en[0] = 1'b0;
      if (s == 43) ch_en[0] = 1'b1;
      if (s == 51) div[7:0] = 8'd8;
      if (s == 57) div[7:0] = 8'd3;
    end
    check("cnt_before_drop", lock_loss_cnt, 8'd0);

    // Lock drop in RUN; ch0 would pulse at cycle 67 if not masked.
    pll_locked = 1'b0;
    step_to(66);
    check("drop_rst_c66", rst_out, 2'b00);
    check("drop_ready_c66", ready, 1'b1);
    step_to(67);
    check("drop_rst_c67", rst_out, 2'b11);
    check("drop_ready_c67", ready, 1'b0);
    check("drop_ce_c67", ce_out, 2'b00);
    check("drop_cnt_c67", lock_loss_cnt, 8'd1);

    // Three-cycle glitch during FILTER restarts qualification, no count.
    pll_locked  = 1'b1;
    phase[15:8] = 8'd7;
    step_to(71);
    pll_locked = 1'b0;
    step_to(74);
    pll_locked = 1'b1;
    step_to(84);
    check("glitch_rst_c84", rst_out, 2'b11);
    step_to(85);
    check("glitch_rst_c85", rst_out, 2'b10);
    check("glitch_cnt", lock_loss_cnt, 8'd1);
    for (int s = 89; s <= 93; s++) begin
      step_to(s);
      check($sformatf("ph7_ce1_c%0d", s), ce_out[1], (s == 93));
      if (s == 89) check("glitch_rst_c89", rst_out, 2'b00);
      if (s == 90) check("glitch_ready_c90", ready, 1'b1);
    end

    // Repeated drops (first from RUN, then from RELEASE) until saturation.
    for (int k = 0; k < 256; k++) begin
      pll_locked = 1'b1;
      got        = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (!rst_out[0]) begin
          got = 1'b1;
          break;
        end
        step();
      end
      check($sformatf("loop_release_k%0d", k), got, 1'b1);
      pll_locked = 1'b0;
      step();
      step();
      step();
      check($sformatf("loop_rst_k%0d", k), rst_out, 2'b11);
      check($sformatf("loop_cnt_k%0d", k), lock_loss_cnt, (k + 2 > 255) ? 255 : k + 2);
    end

    // Async reset between edges mid-RELEASE, then the full sequence again.
    pll_locked = 1'b1;
    got        = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!rst_out[0]) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("ar_release", got, 1'b1);
    step();
    check("ar_pre_rst", rst_out, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    check("ar_rst", rst_out, 2'b11);
    check("ar_ready", ready, 1'b0);
    check("ar_ce", ce_out, 2'b00);
    check("ar_cnt", lock_loss_cnt, 8'd0);
    #2;
    reset = 1'b0;
    cyc   = 0;
    step_to(10);
    check("ar_rst_c10", rst_out, 2'b11);
    step_to(11);
    check("ar_rst_c11", rst_out, 2'b10);
    step_to(15);
    check("ar_rst_c15", rst_out, 2'b00);
    check("ar_ready_c15", ready, 1'b0);
    step_to(16);
    check("ar_ready_c16", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
